// File: rtl/ofs_fim_axis_pipeline_if.sv
// pcie_ss_axis_if: AXI-Stream bundle used by the FIM pipeline blocks.
//   DATA_W : tdata width in bits; tkeep is DATA_W/8 bits wide
//   USER_W : tuser_vendor width in bits
// Modports:
//   sink   : stream consumer; receives tvalid and payload, drives tready
//   source : stream producer; drives tvalid and payload, receives tready
interface pcie_ss_axis_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned USER_W = 10
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic [USER_W-1:0]     tuser_vendor;

  modport sink   (input  tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
  modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input  tready);
endinterface

// File: rtl/ofs_fim_axis_pipeline.sv
// ofs_fim_axis_pipeline: configurable AXI-Stream register slice chain.
//   MODE 0 : skid-buffer stages (registered upstream tready)
//   MODE 1 : simple pipeline register stages
//   MODE 2 : bypass, pure wires
//   PL_DEPTH stages are cascaded in MODE 0/1 (latency PL_DEPTH cycles).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (clears valid flags; no effect in MODE 2)
//   axis_s : input stream (sink modport)
//   axis_m : output stream (source modport)
// Build option:
//   OFS_FIM_AXIS_PIPELINE_PAYLOAD_RESET_EN - when defined, payload registers
//   also clear on reset; otherwise only valid/ready state is reset.
module ofs_fim_axis_pipeline #(
  parameter int unsigned MODE        = 0,
  parameter int unsigned PL_DEPTH    = 1,
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  pcie_ss_axis_if.sink   axis_s,
  pcie_ss_axis_if.source axis_m
);

  localparam int unsigned KW = TDATA_WIDTH / 8;
  localparam int unsigned PW = TDATA_WIDTH + KW + 1 + TUSER_WIDTH;

  generate
    if (MODE == 2) begin : g_bypass
      assign axis_m.tvalid       = axis_s.tvalid;
      assign axis_m.tdata        = axis_s.tdata;
      assign axis_m.tkeep        = axis_s.tkeep;
      assign axis_m.tlast        = axis_s.tlast;
      assign axis_m.tuser_vendor = axis_s.tuser_vendor;
      assign axis_s.tready       = axis_m.tready;

      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n};
    end else begin : g_pipe
      // Index 0 is the block input, index PL_DEPTH the block output.
      logic [PW-1:0] w_data  [PL_DEPTH+1];
      logic          w_valid [PL_DEPTH+1];
      logic          w_ready [PL_DEPTH+1];

      assign w_data[0]  = {axis_s.tdata, axis_s.tkeep, axis_s.tlast, axis_s.tuser_vendor};
      assign w_valid[0] = axis_s.tvalid;
      assign axis_s.tready = w_ready[0];

      assign {axis_m.tdata, axis_m.tkeep, axis_m.tlast, axis_m.tuser_vendor} = w_data[PL_DEPTH];
      assign axis_m.tvalid     = w_valid[PL_DEPTH];
      assign w_ready[PL_DEPTH] = axis_m.tready;

      for (genvar gi = 0; gi < int'(PL_DEPTH); gi++) begin : g_stage
        if (MODE == 0) begin : g_skid
          logic          r_out_valid;
          logic          r_skid_valid;
          logic          r_in_ready;
          logic [PW-1:0] r_out_data;
          logic [PW-1:0] r_skid_data;
          logic          w_load;
          logic          w_in_fire;
          logic          w_skid_nxt;

          // Upstream tready is the registered inverse of next-cycle skid
          // occupancy, so it never sees downstream tready combinationally.
          always_comb begin
            w_load     = !r_out_valid || w_ready[gi+1];
            w_in_fire  = w_valid[gi] && r_in_ready;
            w_skid_nxt = w_load ? 1'b0 : (r_skid_valid || w_in_fire);
          end

          always_ff @(posedge clk) begin
            if (!rst_n) begin
              r_out_valid  <= 1'b0;
              r_skid_valid <= 1'b0;
              r_in_ready   <= 1'b0;
            end else begin
              r_skid_valid <= w_skid_nxt;
              r_in_ready   <= !w_skid_nxt;
              if (w_load) begin
                r_out_valid <= r_skid_valid || w_in_fire;
              end
            end
          end

          // Payload kept in its own block so the non-reset build has no
          // reset fanout into the data registers.
          always_ff @(posedge clk) begin
`ifdef OFS_FIM_AXIS_PIPELINE_PAYLOAD_RESET_EN
            if (!rst_n) begin
              r_out_data  <= '0;
              r_skid_data <= '0;
            end else
`endif
            begin
              if (w_load) begin
                if (r_skid_valid) begin
                  r_out_data <= r_skid_data;
                end else if (w_in_fire) begin
                  r_out_data <= w_data[gi];
                end
              end else if (w_in_fire) begin
                r_skid_data <= w_data[gi];
              end
            end
          end

          assign w_valid[gi+1] = r_out_valid;
          assign w_data[gi+1]  = r_out_data;
          assign w_ready[gi]   = r_in_ready;
        end else begin : g_reg
          logic          r_valid;
          logic [PW-1:0] r_data;
          logic          w_in_ready;

          assign w_in_ready = !r_valid || w_ready[gi+1];

          always_ff @(posedge clk) begin
            if (!rst_n) begin
              r_valid <= 1'b0;
            end else if (w_in_ready) begin
              r_valid <= w_valid[gi];
            end
          end

          always_ff @(posedge clk) begin
`ifdef OFS_FIM_AXIS_PIPELINE_PAYLOAD_RESET_EN
            if (!rst_n) begin
              r_data <= '0;
            end else
`endif
            begin
              if (w_in_ready && w_valid[gi]) begin
                r_data <= w_data[gi];
              end
            end
          end

          assign w_valid[gi+1] = r_valid;
          assign w_data[gi+1]  = r_data;
          assign w_ready[gi]   = w_in_ready;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ofs_fim_axis_pipeline.sv
// Scoreboard bench: three instances (skid x1, pipeline x3, bypass), each with
// an expected-beat queue filled on input accept and drained on output accept.
module tb_ofs_fim_axis_pipeline;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 10;
  localparam int unsigned PW = DW + DW/8 + 1 + UW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) s0 ();
  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) m0 ();
  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) s1 ();
  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) m1 ();
  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) s2 ();
  pcie_ss_axis_if #(.DATA_W(DW), .USER_W(UW)) m2 ();

  ofs_fim_axis_pipeline #(.MODE(0), .PL_DEPTH(1), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW))
    u_skid (.clk(clk), .rst_n(rst_n), .axis_s(s0), .axis_m(m0));
  ofs_fim_axis_pipeline #(.MODE(1), .PL_DEPTH(3), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW))
    u_pipe (.clk(clk), .rst_n(rst_n), .axis_s(s1), .axis_m(m1));
  ofs_fim_axis_pipeline #(.MODE(2), .PL_DEPTH(1), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW))
    u_byp  (.clk(clk), .rst_n(rst_n), .axis_s(s2), .axis_m(m2));

  typedef struct {
    logic [PW-1:0] pl;
    int unsigned   cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned pop0     = 0;
  int unsigned pop1     = 0;
  int unsigned pop2     = 0;
  int unsigned min_lat1 = 32'hFFFF_FFFF;
  logic        exact_lat0 = 1'b0;
  logic        rand_rdy1  = 1'b0;
  logic        byp_chk    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [DW-1:0] d, input logic [DW/8-1:0] k,
                                       input logic l, input logic [UW-1:0] u);
    return {d, k, l, u};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: sampled on the falling edge, where every signal already holds
  // the value it will have at the next rising (transfer) edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete();
    end else begin
      if (s0.tvalid && s0.tready)
        q0.push_back('{pl: {s0.tdata, s0.tkeep, s0.tlast, s0.tuser_vendor}, cyc: cyc});
      if (m0.tvalid && m0.tready) begin
        pop0++;
        check("m0_expected_beat", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("m0_payload", {m0.tdata, m0.tkeep, m0.tlast, m0.tuser_vendor}, e.pl);
          if (exact_lat0) check("m0_latency", cyc - e.cyc, 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int unsigned lat;
    if (!rst_n) begin
      q1.delete();
    end else begin
      if (s1.tvalid && s1.tready)
        q1.push_back('{pl: {s1.tdata, s1.tkeep, s1.tlast, s1.tuser_vendor}, cyc: cyc});
      if (m1.tvalid && m1.tready) begin
        pop1++;
        check("m1_expected_beat", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          lat = cyc - e.cyc;
          check("m1_payload", {m1.tdata, m1.tkeep, m1.tlast, m1.tuser_vendor}, e.pl);
          check("m1_latency_ge3", lat >= 3, 1);
          if (lat < min_lat1) min_lat1 = lat;
        end
      end
    end
  end

  // Bypass ignores reset entirely, so its scoreboard does too.
  always @(negedge clk) begin
    exp_t e;
    if (s2.tvalid && s2.tready)
      q2.push_back('{pl: {s2.tdata, s2.tkeep, s2.tlast, s2.tuser_vendor}, cyc: cyc});
    if (m2.tvalid && m2.tready) begin
      pop2++;
      check("m2_expected_beat", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("m2_payload", {m2.tdata, m2.tkeep, m2.tlast, m2.tuser_vendor}, e.pl);
        check("m2_latency", cyc - e.cyc, 0);
      end
    end
    if (byp_chk) begin
      check("byp_tvalid", m2.tvalid, s2.tvalid);
      check("byp_tready", s2.tready, m2.tready);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy1) m1.tready = ($urandom_range(0, 1) == 1);
  end

  task automatic send0(input logic [PW-1:0] p);
    logic f;
    int unsigned n;
    {s0.tdata, s0.tkeep, s0.tlast, s0.tuser_vendor} = p;
    s0.tvalid = 1'b1;
    n = 0;
    f = 1'b0;
    while (!f && n < 100) begin
      @(negedge clk);
      f = s0.tvalid && s0.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!f) check("s0_accept_timeout", f, 1);
  endtask

  task automatic send1(input logic [PW-1:0] p);
    logic f;
    int unsigned n;
    {s1.tdata, s1.tkeep, s1.tlast, s1.tuser_vendor} = p;
    s1.tvalid = 1'b1;
    n = 0;
    f = 1'b0;
    while (!f && n < 200) begin
      @(negedge clk);
      f = s1.tvalid && s1.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!f) check("s1_accept_timeout", f, 1);
  endtask

  initial begin
    int unsigned n;
    int unsigned saved;
    rst_n = 1'b0;
    {s0.tvalid, s0.tdata, s0.tkeep, s0.tlast, s0.tuser_vendor} = '0;
    {s1.tvalid, s1.tdata, s1.tkeep, s1.tlast, s1.tuser_vendor} = '0;
    {s2.tvalid, s2.tdata, s2.tkeep, s2.tlast, s2.tuser_vendor} = '0;
    m0.tready = 1'b0;
    m1.tready = 1'b0;
    m2.tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m0_tvalid", m0.tvalid, 0);
    check("rst_s0_tready", s0.tready, 0);
    check("rst_m1_tvalid", m1.tvalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_pre_edge_s0_tready", s0.tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rel_s0_tready", s0.tready, 1);

    // Streaming: 8 back-to-back beats, 1 cycle latency
    @(posedge clk); #1;
    m0.tready  = 1'b1;
    exact_lat0 = 1'b1;
    for (int i = 0; i < 8; i++) send0(mk(DW'(i), '1, (i == 7), UW'($urandom)));
    s0.tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exact_lat0 = 1'b0;
    check("stream_count", pop0, 8);

    // Stall: downstream blocked, exactly two beats absorbed
    m0.tready = 1'b0;
    n = 0;
    {s0.tdata, s0.tkeep, s0.tlast, s0.tuser_vendor} = mk(DW'(100 + n), '1, 1'b0, UW'(n));
    s0.tvalid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (s0.tvalid && s0.tready) n++;
      @(posedge clk); #1;
      {s0.tdata, s0.tkeep, s0.tlast, s0.tuser_vendor} = mk(DW'(100 + n), '1, 1'b0, UW'(n));
    end
    @(negedge clk);
    check("stall_accepted", n, 2);
    check("stall_s0_tready", s0.tready, 0);
    check("stall_m0_tvalid", m0.tvalid, 1);
    @(posedge clk); #1;
    m0.tready = 1'b1;
    while (n < 6) begin
      send0(mk(DW'(100 + n), '1, (n == 5), UW'(n)));
      n++;
    end
    s0.tvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stall_drain_count", pop0, 14);

    // Mid-operation reset with two beats buffered
    m0.tready = 1'b0;
    send0(mk(32'hA5A5_0001, '1, 1'b0, 10'h11));
    send0(mk(32'hA5A5_0002, '1, 1'b1, 10'h22));
    s0.tvalid = 1'b0;
    @(negedge clk);
    check("full_s0_tready", s0.tready, 0);
    saved = pop0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    s0.tvalid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_m0_tvalid", m0.tvalid, 0);
    check("mrst_s0_tready", s0.tready, 0);
    @(posedge clk); #1;
    s0.tvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_rel_s0_tready", s0.tready, 1);
    check("mrst_rel_m0_tvalid", m0.tvalid, 0);
`ifdef OFS_FIM_AXIS_PIPELINE_PAYLOAD_RESET_EN
    check("mrst_m0_tdata_cleared", m0.tdata, 0);
`endif
    @(posedge clk); #1;
    m0.tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mrst_no_stale_beats", pop0, saved);

    // Random backpressure through 3 pipeline stages
    rand_rdy1 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(0, 1) == 0) begin
        s1.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      send1(mk(DW'($urandom), (DW/8)'($urandom), 1'($urandom), UW'(i)));
    end
    s1.tvalid = 1'b0;
    rand_rdy1 = 1'b0;
    m1.tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pipe_count", pop1, 1000);
    check("pipe_min_latency", min_lat1, 3);
    check("pipe_queue_empty", q1.size(), 0);

    // Bypass, including a reset pulse that must not disturb it
    byp_chk = 1'b1;
    for (int k = 0; k < 40; k++) begin
      {s2.tdata, s2.tkeep, s2.tlast, s2.tuser_vendor} =
        mk(DW'($urandom), (DW/8)'($urandom), 1'($urandom), UW'($urandom));
      s2.tvalid = 1'($urandom);
      m2.tready = 1'($urandom);
      rst_n = !(k >= 10 && k < 14);
      @(negedge clk);
      check("byp_payload", {m2.tdata, m2.tkeep, m2.tlast, m2.tuser_vendor},
            {s2.tdata, s2.tkeep, s2.tlast, s2.tuser_vendor});
      @(posedge clk); #1;
    end
    byp_chk = 1'b0;
    rst_n = 1'b1;
    s2.tvalid = 1'b0;
    check("byp_queue_empty", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
